// File: rtl/pc_redirect_pkg.sv
// Shared types and helpers for the fetch-stage PC redirect unit.
// prio_sel is a fixed-priority finder: the lowest set bit wins.
package pc_redirect_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_STEP  = 4;
  localparam int STEP          = DEFAULT_STEP;
  localparam int STEP_LSB      = $clog2(STEP);
  localparam int MAX_SRC       = 32;
  localparam int SRC_IDX_W     = 5;

  typedef enum logic [1:0] {
    SRC_EX_MISPREDICT = 2'd0,
    SRC_JALR          = 2'd1,
    SRC_JAL           = 2'd2,
    SRC_BTB           = 2'd3
  } src_e;

  typedef struct packed {
    logic                 found;
    logic [SRC_IDX_W-1:0] index;
  } prio_t;

  // Scanning from the top down lets the lowest valid index overwrite the result last.
  function automatic prio_t prio_sel(input logic [MAX_SRC-1:0] valid);
    prio_t r;
    r.found = 1'b0;
    r.index = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (valid[i]) begin
        r.found = 1'b1;
        r.index = SRC_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Request/response bundle between the fetch control logic and the PC redirect unit.
interface pc_redirect_unit_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 16
);

  logic                       enable;
  logic [NUM_SRC-1:0]         redirect_valid;
  logic [NUM_SRC*WIDTH-1:0]   redirect_target;
  logic [WIDTH-1:0]           out;
  logic                       pending;
  logic                       misaligned;
  logic [CNT_WIDTH-1:0]       redirect_count;

  modport master (
    output enable, redirect_valid, redirect_target,
    input  out, pending, misaligned, redirect_count
  );

  modport slave (
    input  enable, redirect_valid, redirect_target,
    output out, pending, misaligned, redirect_count
  );

endinterface

// File: rtl/pc_redirect_arbiter.sv
// Fixed-priority redirect select; only the winning channel's target is ever read,
// so undriven targets on idle channels cannot leak X into the PC.
module pc_redirect_arbiter
  import pc_redirect_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_SRC-1:0]       valid,
  input  logic [NUM_SRC*WIDTH-1:0] targets,
  output logic [SEL_W-1:0]         sel,
  output logic                     live,
  output logic [WIDTH-1:0]         target
);

  prio_t pick;

  always_comb begin
    pick   = prio_sel(MAX_SRC'(valid));
    live   = pick.found;
    sel    = SEL_W'(pick.index);
    target = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick.found && pick.index == SRC_IDX_W'(i)) begin
        target = targets[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with prioritised redirects, stall-time redirect capture,
// misalignment flag and a saturating count of applied redirects.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter int               NUM_SRC      = 4,
  parameter int               STEP         = DEFAULT_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0060),
  parameter int               CNT_WIDTH    = 16
) (
  input logic              clk,
  input logic              rst,
  pc_redirect_unit_if.slave bus
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LSB   = $clog2(STEP);

  logic [SEL_W-1:0]     sel;
  logic                 live;
  logic [WIDTH-1:0]     sel_target;
  logic [WIDTH-1:0]     pc;
  logic                 pending;
  logic [WIDTH-1:0]     pending_target;
  logic [SEL_W-1:0]     pending_src;
  logic [CNT_WIDTH-1:0] count;

  pc_redirect_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_arbiter (
    .valid   (bus.redirect_valid),
    .targets (bus.redirect_target),
    .sel     (sel),
    .live    (live),
    .target  (sel_target)
  );

  // A live redirect always beats a captured one; during a stall an equal-or-higher
  // priority request replaces the capture so the newest value wins on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_VECTOR;
      pending        <= 1'b0;
      pending_target <= '0;
      pending_src    <= '0;
      count          <= '0;
    end else if (bus.enable) begin
      if (live) begin
        pc      <= sel_target;
        pending <= 1'b0;
        if (~&count) count <= count + 1'b1;
      end else if (pending) begin
        pc      <= pending_target;
        pending <= 1'b0;
        if (~&count) count <= count + 1'b1;
      end else begin
        pc <= pc + WIDTH'(STEP);
      end
    end else if (live && (!pending || sel <= pending_src)) begin
      pending        <= 1'b1;
      pending_target <= sel_target;
      pending_src    <= sel;
    end
  end

  generate
    if (LSB == 0) begin : g_no_align
      assign bus.misaligned = 1'b0;
    end else begin : g_align
      assign bus.misaligned = |pc[LSB-1:0];
    end
  endgenerate

  assign bus.out            = pc;
  assign bus.pending        = pending;
  assign bus.redirect_count = count;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: expected PC state is queued as each
// cycle's stimulus is driven and compared one cycle later.
module tb_pc_redirect_unit;
  import pc_redirect_pkg::*;

  typedef struct packed {
    logic         en;
    logic [3:0]   v;
    logic [127:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [1:0] sat_sb[$];

  pc_redirect_unit_if #(.WIDTH(32), .NUM_SRC(4), .CNT_WIDTH(16)) bus ();
  pc_redirect_unit_if #(.WIDTH(32), .NUM_SRC(4), .CNT_WIDTH(2))  sat_bus ();

  pc_redirect_unit #(
    .WIDTH(32), .NUM_SRC(4), .STEP(4), .RESET_VECTOR(32'h0000_0060), .CNT_WIDTH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_redirect_unit #(
    .WIDTH(32), .NUM_SRC(4), .STEP(4), .RESET_VECTOR(32'h0000_0060), .CNT_WIDTH(2)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic en, input logic [3:0] v,
                               input logic [31:0] t0, input logic [31:0] t1,
                               input logic [31:0] t2, input logic [31:0] t3);
    stim_t s;
    s.en  = en;
    s.v   = v;
    s.tgt = {t3, t2, t1, t0};
    return s;
  endfunction

  function automatic exp_t ex(input logic [31:0] pc, input logic pend,
                              input logic mis, input logic [15:0] cnt);
    exp_t e;
    e.pc   = pc;
    e.pend = pend;
    e.mis  = mis;
    e.cnt  = cnt;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus.enable          = s.en;
    bus.redirect_valid  = s.v;
    bus.redirect_target = s.tgt;
  endtask

  task automatic test_reset;
    stim_t st[3];
    exp_t  xp[3];
    exp_t  e;
    rst = 1'b1;
    drive(mk(1'b0, 4'b0000, '0, '0, '0, '0));
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out !== 32'h60) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", bus.out, 32'h60); end
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("[TB] FAIL reset_pending got=%b exp=0", bus.pending); end
    checks++; if (bus.redirect_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.redirect_count); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) st[i] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    xp[0] = ex(32'h64, 1'b0, 1'b0, 16'd0);
    xp[1] = ex(32'h68, 1'b0, 1'b0, 16'd0);
    xp[2] = ex(32'h6C, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      sb.push_back(xp[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (bus.out !== e.pc) begin failures++; $display("[TB] FAIL incr_pc[%0d] got=%h exp=%h", i, bus.out, e.pc); end
      checks++; if (bus.pending !== e.pend) begin failures++; $display("[TB] FAIL incr_pending[%0d] got=%b exp=%b", i, bus.pending, e.pend); end
      checks++; if (bus.redirect_count !== e.cnt) begin failures++; $display("[TB] FAIL incr_count[%0d] got=%0d exp=%0d", i, bus.redirect_count, e.cnt); end
    end
  endtask

  task automatic test_priority;
    stim_t st[2];
    exp_t  xp[2];
    exp_t  e;
    st[0] = mk(1'b1, 4'b1010, 32'hx, 32'h200, 32'hx, 32'h300);
    st[1] = mk(1'b1, 4'b0000, 32'hx, 32'hx, 32'hx, 32'hx);
    xp[0] = ex(32'h200, 1'b0, 1'b0, 16'd1);
    xp[1] = ex(32'h204, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 2; i++) begin
      drive(st[i]);
      sb.push_back(xp[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (bus.out !== e.pc) begin failures++; $display("[TB] FAIL prio_pc[%0d] got=%h exp=%h", i, bus.out, e.pc); end
      checks++; if (bus.pending !== e.pend) begin failures++; $display("[TB] FAIL prio_pending[%0d] got=%b exp=%b", i, bus.pending, e.pend); end
      checks++; if (bus.redirect_count !== e.cnt) begin failures++; $display("[TB] FAIL prio_count[%0d] got=%0d exp=%0d", i, bus.redirect_count, e.cnt); end
    end
  endtask

  task automatic test_stall_capture;
    stim_t st[9];
    exp_t  xp[9];
    exp_t  e;
    st[0] = mk(1'b0, 4'b0000, '0, '0, '0, '0);
    st[1] = mk(1'b0, 4'b1000, '0, '0, '0, 32'h400);
    st[2] = mk(1'b0, 4'b0001, 32'h500, '0, '0, '0);
    st[3] = mk(1'b0, 4'b1000, '0, '0, '0, 32'h600);
    st[4] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    st[5] = mk(1'b0, 4'b0001, 32'h800, '0, '0, '0);
    st[6] = mk(1'b0, 4'b0001, 32'h900, '0, '0, '0);
    st[7] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    st[8] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    xp[0] = ex(32'h204, 1'b0, 1'b0, 16'd1);
    xp[1] = ex(32'h204, 1'b1, 1'b0, 16'd1);
    xp[2] = ex(32'h204, 1'b1, 1'b0, 16'd1);
    xp[3] = ex(32'h204, 1'b1, 1'b0, 16'd1);
    xp[4] = ex(32'h500, 1'b0, 1'b0, 16'd2);
    xp[5] = ex(32'h500, 1'b1, 1'b0, 16'd2);
    xp[6] = ex(32'h500, 1'b1, 1'b0, 16'd2);
    xp[7] = ex(32'h900, 1'b0, 1'b0, 16'd3);
    xp[8] = ex(32'h904, 1'b0, 1'b0, 16'd3);
    for (int i = 0; i < 9; i++) begin
      drive(st[i]);
      sb.push_back(xp[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (bus.out !== e.pc) begin failures++; $display("[TB] FAIL stall_pc[%0d] got=%h exp=%h", i, bus.out, e.pc); end
      checks++; if (bus.pending !== e.pend) begin failures++; $display("[TB] FAIL stall_pending[%0d] got=%b exp=%b", i, bus.pending, e.pend); end
      checks++; if (bus.redirect_count !== e.cnt) begin failures++; $display("[TB] FAIL stall_count[%0d] got=%0d exp=%0d", i, bus.redirect_count, e.cnt); end
    end
  endtask

  task automatic test_live_beats_pending;
    stim_t st[3];
    exp_t  xp[3];
    exp_t  e;
    st[0] = mk(1'b0, 4'b0001, 32'h500, '0, '0, '0);
    st[1] = mk(1'b1, 4'b0100, '0, '0, 32'h700, '0);
    st[2] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    xp[0] = ex(32'h904, 1'b1, 1'b0, 16'd3);
    xp[1] = ex(32'h700, 1'b0, 1'b0, 16'd4);
    xp[2] = ex(32'h704, 1'b0, 1'b0, 16'd4);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      sb.push_back(xp[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (bus.out !== e.pc) begin failures++; $display("[TB] FAIL live_pc[%0d] got=%h exp=%h", i, bus.out, e.pc); end
      checks++; if (bus.pending !== e.pend) begin failures++; $display("[TB] FAIL live_pending[%0d] got=%b exp=%b", i, bus.pending, e.pend); end
      checks++; if (bus.redirect_count !== e.cnt) begin failures++; $display("[TB] FAIL live_count[%0d] got=%0d exp=%0d", i, bus.redirect_count, e.cnt); end
    end
  endtask

  task automatic test_wrap_misalign;
    stim_t st[7];
    exp_t  xp[7];
    exp_t  e;
    st[0] = mk(1'b1, 4'b0010, '0, 32'hFFFF_FFF8, '0, '0);
    st[1] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    st[2] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    st[3] = mk(1'b1, 4'b0001, 32'h102, '0, '0, '0);
    st[4] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    st[5] = mk(1'b1, 4'b0000, '0, '0, '0, '0);
    st[6] = mk(1'b1, 4'b0001, 32'h200, '0, '0, '0);
    xp[0] = ex(32'hFFFF_FFF8, 1'b0, 1'b0, 16'd5);
    xp[1] = ex(32'hFFFF_FFFC, 1'b0, 1'b0, 16'd5);
    xp[2] = ex(32'h0000_0000, 1'b0, 1'b0, 16'd5);
    xp[3] = ex(32'h102, 1'b0, 1'b1, 16'd6);
    xp[4] = ex(32'h106, 1'b0, 1'b1, 16'd6);
    xp[5] = ex(32'h10A, 1'b0, 1'b1, 16'd6);
    xp[6] = ex(32'h200, 1'b0, 1'b0, 16'd7);
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      sb.push_back(xp[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (bus.out !== e.pc) begin failures++; $display("[TB] FAIL wrap_pc[%0d] got=%h exp=%h", i, bus.out, e.pc); end
      checks++; if (bus.misaligned !== e.mis) begin failures++; $display("[TB] FAIL wrap_misaligned[%0d] got=%b exp=%b", i, bus.misaligned, e.mis); end
      checks++; if (bus.redirect_count !== e.cnt) begin failures++; $display("[TB] FAIL wrap_count[%0d] got=%0d exp=%0d", i, bus.redirect_count, e.cnt); end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    drive(mk(1'b0, 4'b0100, '0, '0, 32'hABC, '0));
    sb.push_back(ex(32'h200, 1'b1, 1'b0, 16'd7));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++; if (bus.pending !== e.pend) begin failures++; $display("[TB] FAIL areset_pre_pending got=%b exp=%b", bus.pending, e.pend); end
    checks++; if (bus.out !== e.pc) begin failures++; $display("[TB] FAIL areset_pre_pc got=%h exp=%h", bus.out, e.pc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out !== 32'h60) begin failures++; $display("[TB] FAIL areset_pc got=%h exp=%h", bus.out, 32'h60); end
    checks++; if (bus.pending !== 1'b0) begin failures++; $display("[TB] FAIL areset_pending got=%b exp=0", bus.pending); end
    checks++; if (bus.redirect_count !== 16'd0) begin failures++; $display("[TB] FAIL areset_count got=%0d exp=0", bus.redirect_count); end
    #1 rst = 1'b0;
    drive(mk(1'b1, 4'b0000, '0, '0, '0, '0));
    sb.push_back(ex(32'h64, 1'b0, 1'b0, 16'd0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++; if (bus.out !== e.pc) begin failures++; $display("[TB] FAIL areset_post_pc got=%h exp=%h", bus.out, e.pc); end
    checks++; if (bus.pending !== e.pend) begin failures++; $display("[TB] FAIL areset_post_pending got=%b exp=%b", bus.pending, e.pend); end
  endtask

  task automatic test_saturation;
    logic [1:0]  exp_cnt;
    logic [31:0] tgt;
    for (int i = 0; i < 5; i++) begin
      tgt = 32'h1000 + 32'(i * 16);
      sat_bus.enable          = 1'b1;
      sat_bus.redirect_valid  = 4'b0001;
      sat_bus.redirect_target = {96'h0, tgt};
      sat_sb.push_back((i < 3) ? 2'(i + 1) : 2'd3);
      @(posedge clk); #1;
      exp_cnt = sat_sb.pop_front();
      checks++; if (sat_bus.redirect_count !== exp_cnt) begin failures++; $display("[TB] FAIL sat_count[%0d] got=%0d exp=%0d", i, sat_bus.redirect_count, exp_cnt); end
      checks++; if (sat_bus.out !== tgt) begin failures++; $display("[TB] FAIL sat_pc[%0d] got=%h exp=%h", i, sat_bus.out, tgt); end
    end
    sat_bus.redirect_valid = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sat_bus.enable          = 1'b1;
    sat_bus.redirect_valid  = 4'b0000;
    sat_bus.redirect_target = '0;
    test_reset();
    test_priority();
    test_stall_capture();
    test_live_beats_pending();
    test_wrap_misalign();
    test_async_reset();
    test_saturation();
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
